// File: rtl/lift_pkg.sv
// Shared definitions for the two-floor lift controller: decoder action codes,
// controller state encoding and default timing constants.
package lift_pkg;

    // Action codes understood by the downstream seven-segment decoder
    localparam logic [2:0] ACT_DN   = 3'b000;
    localparam logic [2:0] ACT_A1   = 3'b001;
    localparam logic [2:0] ACT_UP   = 3'b010;
    localparam logic [2:0] ACT_A2   = 3'b011;
    localparam logic [2:0] ACT_R1   = 3'b100;
    localparam logic [2:0] ACT_R2   = 3'b101;
    localparam logic [2:0] ACT_NONE = 3'b110;

    // Default timing at a 50 MHz system clock
    localparam int DOOR_CYCLES_DEF   = 50_000_000;
    localparam int TRAVEL_CYCLES_DEF = 250_000_000;
    localparam int CNT_W_DEF         = 28;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_PARK1,
        ST_PARK2,
        ST_REQ1,
        ST_REQ2,
        ST_MOVE_UP,
        ST_MOVE_DN,
        ST_FAULT
    } lift_state_t;

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter shared by door dwell, door closing and travel timing.
// The count parks at zero; expired is only meaningful while enabled.
module lift_timer #(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // Load has priority; otherwise count down to zero while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = en && (count == '0);

endmodule

// File: rtl/lift_action_fsm.sv
// Two-floor lift controller. Latches calls, sequences door dwell, door closing
// and travel, and drives the registered action code for the segment decoder.
// Optional build macro LIFT_SYNC_EN: when defined, every button and sensor
// input passes through a two-flop synchronizer before use.
// Handshake note: there is no valid/ready traffic here; calls and sensors are
// plain levels sampled on every rising clk edge.
module lift_action_fsm
    import lift_pkg::*;
#(
    parameter int DOOR_CYCLES   = DOOR_CYCLES_DEF,
    parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       call1,
    input  logic       call2,
    input  logic       at_floor1,
    input  logic       at_floor2,
    output logic [2:0] action,
    output logic       motor_up,
    output logic       motor_dn,
    output logic       door_open,
    output logic       fault,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);

    logic        c1, c2, f1, f2;
    lift_state_t state, state_nx;
    logic [1:0]  pending, pending_nx;   // bit 0 = floor 1, bit 1 = floor 2
    logic        reload;
    logic        tmr_load, tmr_en, tmr_expired;
    logic [CNT_W-1:0] tmr_val;
    logic [2:0]  action_nx;
    logic        up_nx, dn_nx, door_nx, fault_nx;

`ifdef LIFT_SYNC_EN
    logic [3:0] sync_a, sync_b;

    // Two-flop synchronizer for buttons and floor sensors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {call1, call2, at_floor1, at_floor2};
            sync_b <= sync_a;
        end
    end

    assign {c1, c2, f1, f2} = sync_b;
`else
    assign {c1, c2, f1, f2} = {call1, call2, at_floor1, at_floor2};
`endif

    lift_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    // State, pending calls and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            pending   <= 2'b00;
            action    <= ACT_NONE;
            motor_up  <= 1'b0;
            motor_dn  <= 1'b0;
            door_open <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nx;
            pending   <= pending_nx;
            action    <= action_nx;
            motor_up  <= up_nx;
            motor_dn  <= dn_nx;
            door_open <= door_nx;
            fault     <= fault_nx;
        end
    end

    // Next state, pending-call update and timer control
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        reload     = 1'b0;
        if (f1 && f2) begin
            // Contradictory sensors override everything
            state_nx   = ST_FAULT;
            pending_nx = 2'b00;
        end else begin
            case (state)
                ST_INIT: begin
                    if (f1)      state_nx = ST_PARK1;
                    else if (f2) state_nx = ST_PARK2;
                    else         state_nx = ST_MOVE_DN;   // home to floor 1
                end
                ST_PARK1: begin
                    pending_nx[1] = pending[1] | c2;
                    if (c1)                            reload   = 1'b1;
                    else if (tmr_expired && pending[1]) state_nx = ST_REQ2;
                end
                ST_PARK2: begin
                    pending_nx[0] = pending[0] | c1;
                    if (c2)                            reload   = 1'b1;
                    else if (tmr_expired && pending[0]) state_nx = ST_REQ1;
                end
                ST_REQ1: begin
                    pending_nx = pending | {c2, c1};
                    if (tmr_expired) state_nx = ST_MOVE_DN;
                end
                ST_REQ2: begin
                    pending_nx = pending | {c2, c1};
                    if (tmr_expired) state_nx = ST_MOVE_UP;
                end
                ST_MOVE_UP: begin
                    pending_nx = pending | {c2, c1};
                    if (f2) begin
                        state_nx      = ST_PARK2;
                        pending_nx[1] = 1'b0;
                    end else if (tmr_expired) begin
                        state_nx   = ST_FAULT;
                        pending_nx = 2'b00;
                    end
                end
                ST_MOVE_DN: begin
                    pending_nx = pending | {c2, c1};
                    if (f1) begin
                        state_nx      = ST_PARK1;
                        pending_nx[0] = 1'b0;
                    end else if (tmr_expired) begin
                        state_nx   = ST_FAULT;
                        pending_nx = 2'b00;
                    end
                end
                ST_FAULT: pending_nx = 2'b00;
                default:  state_nx   = ST_FAULT;
            endcase
        end
        tmr_load = reload || (state_nx != state);
        tmr_val  = (state_nx == ST_MOVE_UP || state_nx == ST_MOVE_DN) ? TRAVEL_LOAD : DOOR_LOAD;
        tmr_en   = (state != ST_INIT) && (state != ST_FAULT);
    end

    // Output values for the state being entered
    always_comb begin
        action_nx = ACT_NONE;
        up_nx     = 1'b0;
        dn_nx     = 1'b0;
        door_nx   = 1'b0;
        fault_nx  = 1'b0;
        case (state_nx)
            ST_PARK1:   begin action_nx = ACT_A1; door_nx = 1'b1; end
            ST_PARK2:   begin action_nx = ACT_A2; door_nx = 1'b1; end
            ST_REQ1:    action_nx = ACT_R1;
            ST_REQ2:    action_nx = ACT_R2;
            ST_MOVE_UP: begin action_nx = ACT_UP; up_nx = 1'b1; end
            ST_MOVE_DN: begin action_nx = ACT_DN; dn_nx = 1'b1; end
            ST_FAULT:   fault_nx = 1'b1;
            default:    action_nx = ACT_NONE;
        endcase
    end

    assign state_dbg = state;

endmodule
